// File: rtl/io_bridge_timer.sv
// io_bridge_timer: IO-bus responder with two down-counting timers, an LED register and a synchronised switch input.
// Read data is registered, giving one cycle of latency. A read in the same cycle as a write returns the old value.
module io_bridge_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h7F00,
  parameter int          LED_WIDTH = 8,
  parameter int          SW_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:2]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 IOWrite,
  output logic [31:0]          PrRD,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] led,
  output logic [1:0]           irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [13:0] BASE_W = BASE_ADDR[15:2];
  logic [13:0]          w_off;
  logic [1:0][3:0]      w_ctrl;
  logic [1:0][31:0]     w_preset;
  logic [1:0][31:0]     w_count;
  logic [31:0]          w_rd;
  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_sw_s1;
  logic [SW_WIDTH-1:0]  r_sw_s2;
  logic                 w_unused;
  // Wrap-around subtraction: anything outside the window lands far above the mapped word offsets.
  assign w_off    = PrAddr[15:2] - BASE_W;
  assign w_unused = ^PrAddr[31:16];
  for (genvar t = 0; t < 2; t++) begin : g_tmr
    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pend;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto;
    assign w_wr_ctrl   = IOWrite && w_off == 14'(4 * t);
    assign w_wr_preset = IOWrite && w_off == 14'(4 * t + 1);
    assign w_auto      = r_ctrl[2:1] == 2'b01;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state  <= IDLE;
        r_ctrl   <= '0;
        r_preset <= '0;
        r_count  <= '0;
        r_pend   <= 1'b0;
      end else begin
        if (w_wr_preset) r_preset <= PrWD;
        case (r_state)
          IDLE: if (r_ctrl[0]) r_state <= LOAD;
          LOAD: begin
            r_count <= r_preset;
            r_state <= CNT;
          end
          CNT: begin
            if (!r_ctrl[0]) r_state <= IDLE;
            else if (r_count > 32'd1) r_count <= r_count - 32'd1;
            else begin
              r_count <= '0;
              r_state <= INT;
            end
          end
          default: begin
            if (w_auto) r_state <= LOAD;
            else begin
              r_ctrl[0] <= 1'b0;
              r_pend    <= 1'b1;
              r_state   <= IDLE;
            end
          end
        endcase
        // A CPU write to CTRL lands after the FSM updates so it wins any same-cycle collision.
        if (w_wr_ctrl) begin
          r_ctrl <= PrWD[3:0];
          r_pend <= 1'b0;
        end
      end
    end
    assign irq[t]      = r_ctrl[3] & (r_pend | (w_auto & r_state == INT));
    assign w_ctrl[t]   = r_ctrl;
    assign w_preset[t] = r_preset;
    assign w_count[t]  = r_count;
  end
  always_comb begin
    w_rd = '0;
    case (w_off)
      14'd0:   w_rd = {28'b0, w_ctrl[0]};
      14'd1:   w_rd = w_preset[0];
      14'd2:   w_rd = w_count[0];
      14'd4:   w_rd = {28'b0, w_ctrl[1]};
      14'd5:   w_rd = w_preset[1];
      14'd6:   w_rd = w_count[1];
      14'd8:   w_rd = 32'(r_led);
      14'd9:   w_rd = 32'(r_sw_s2);
      default: w_rd = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PrRD    <= '0;
      r_led   <= '0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      PrRD    <= w_rd;
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      if (IOWrite && w_off == 14'd8) r_led <= PrWD[LED_WIDTH-1:0];
    end
  end
  assign led = r_led;
endmodule

// File: tb/tb_io_bridge_timer.sv
// tb_io_bridge_timer: directed checks of the IO bridge register map, timers, switch sync and async reset.
module tb_io_bridge_timer;
  logic        clk;
  logic        rst;
  logic [31:2] addr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] PrRD;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic [1:0]  irq;
  int          n_chk;
  int          n_fail;
  int          exp_cnt [13] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};

  io_bridge_timer dut (
    .clk(clk), .rst(rst), .PrAddr(addr), .PrWD(wd), .IOWrite(we),
    .PrRD(PrRD), .sw(sw), .led(led), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:2] wa(input logic [15:0] b);
    return {16'b0, b[15:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] b, input logic [31:0] d);
    addr = wa(b);
    wd   = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] b, input logic [31:0] exp, input string tag);
    addr = wa(b);
    step();
    chk(tag, PrRD, exp);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; addr = '0; wd = '0; we = 1'b0; sw = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_prrd", PrRD, 32'h0);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    wr(16'h7F20, 32'h0000_00A5);
    chk("led_out", 32'(led), 32'hA5);
    rd(16'h7F20, 32'hA5, "led_rd");
    rd(16'h7F0C, 32'h0, "unmapped_0c");
    rd(16'h7F20, 32'hA5, "led_rd2");
    rd(16'h7F28, 32'h0, "unmapped_28");
    wr(16'h7F04, 32'd5);
    rd(16'h7F04, 32'd5, "t0_preset_rd");
    wr(16'h7F00, 32'h9);
    addr = wa(16'h7F08);
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t0_count", PrRD, 32'(5 - i));
      chk("t0_irq", 32'(irq), (i == 5) ? 32'h1 : 32'h0);
    end
    step();
    step();
    chk("t0_irq_held", 32'(irq), 32'h1);
    rd(16'h7F00, 32'h8, "t0_ctrl_en_cleared");
    wr(16'h7F00, 32'h0);
    chk("t0_irq_clear", 32'(irq), 32'h0);
    wr(16'h7F08, 32'hFFFF);
    rd(16'h7F08, 32'h0, "count_ro");
    wr(16'h7F14, 32'd3);
    wr(16'h7F10, 32'hB);
    addr = wa(16'h7F18);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_count", PrRD, 32'(exp_cnt[k-1]));
      chk("t1_irq", 32'(irq), (k == 5 || k == 10) ? 32'h2 : 32'h0);
    end
    wr(16'h7F10, 32'h0);
    repeat (3) step();
    chk("t1_stopped_irq", 32'(irq), 32'h0);
    addr = wa(16'h7F04);
    wd   = 32'h1234;
    we   = 1'b1;
    step();
    we   = 1'b0;
    chk("rbw_old", PrRD, 32'd5);
    step();
    chk("rbw_new", PrRD, 32'h1234);
    sw   = 8'h3C;
    addr = wa(16'h7F24);
    step();
    step();
    chk("sw_sync_lag", PrRD, 32'h0);
    step();
    chk("sw_rd", PrRD, 32'h3C);
    wr(16'h7F00, 32'h9);
    addr = wa(16'h7F08);
    repeat (6) step();
    chk("t0_midcount", PrRD, 32'h1231);
    #3 rst = 1'b1;
    #1;
    chk("async_prrd", PrRD, 32'h0);
    chk("async_led", 32'(led), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    rd(16'h7F08, 32'h0, "async_count");
    rd(16'h7F00, 32'h0, "async_ctrl");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
